// File: rtl/adat_tx_frame_sequencer.sv
// ADAT transmitter frame scheduler: free-running frame timer, start strobe, channel-serial
// fill buffer and frame commit. Optional build macro: ADAT_HOLD_ON_UNDERRUN_EN (repeat last frame on underrun).
module adat_tx_frame_sequencer #(
  parameter int unsigned CLKS_PER_FRAME = 2048,
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned SAMPLE_W       = 24
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [SAMPLE_W-1:0]              s_data,
  input  logic                             s_last,
  input  logic                             user_timecode,
  input  logic                             user_midi,
  input  logic                             user_smux,
  output logic                             start,
  output logic [NUM_CH-1:0][SAMPLE_W-1:0]  audio_out,
  output logic                             timecode,
  output logic                             midi,
  output logic                             smux,
  output logic                             frame_req,
  output logic                             underrun,
  output logic                             sync_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_FRAME);
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_FRAME - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  logic [CNT_W-1:0]                r_cnt;
  logic [IDX_W-1:0]                r_idx;
  logic                            r_full;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] r_fill;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] r_audio;
  logic                            r_start;
  logic                            r_frame_req;
  logic                            r_underrun;
  logic                            r_sync_err;
  logic                            r_timecode;
  logic                            r_midi;
  logic                            r_smux;

  logic w_commit;
  logic w_accept;
  logic w_at_last;
  logic w_misalign;

  assign w_commit   = enable & (r_cnt == CNT_MAX);
  assign w_accept   = s_valid & s_ready;
  assign w_at_last  = (r_idx == IDX_LAST);
  // s_last must coincide exactly with the final channel slot; either mismatch drops the beat.
  assign w_misalign = s_last ^ w_at_last;

  // Commit cycle is closed to input so a beat can never race the buffer hand-off.
  assign s_ready = ~reset & ~r_full & ~w_commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= CNT_MAX;
      r_idx       <= '0;
      r_full      <= 1'b0;
      r_fill      <= '0;
      r_audio     <= '0;
      r_start     <= 1'b0;
      r_frame_req <= 1'b0;
      r_underrun  <= 1'b0;
      r_sync_err  <= 1'b0;
      r_timecode  <= 1'b0;
      r_midi      <= 1'b0;
      r_smux      <= 1'b0;
    end else begin
      r_start     <= w_commit;
      r_frame_req <= w_commit;
      r_underrun  <= w_commit & ~r_full;
      r_sync_err  <= w_accept & w_misalign;

      if (!enable)       r_cnt <= CNT_MAX;
      else if (w_commit) r_cnt <= '0;
      else               r_cnt <= r_cnt + CNT_W'(1);

      if (w_commit) begin
        r_full     <= 1'b0;
        r_idx      <= '0;
        r_timecode <= user_timecode;
        r_midi     <= user_midi;
        r_smux     <= user_smux;
`ifdef ADAT_HOLD_ON_UNDERRUN_EN
        if (r_full) r_audio <= r_fill;
`else
        r_audio    <= r_full ? r_fill : '0;
`endif
      end else if (w_accept) begin
        if (w_misalign) begin
          r_idx  <= '0;
          r_full <= 1'b0;
        end else begin
          r_fill[r_idx] <= s_data;
          if (w_at_last) begin
            r_full <= 1'b1;
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + IDX_W'(1);
          end
        end
      end
    end
  end

  assign start     = r_start;
  assign frame_req = r_frame_req;
  assign underrun  = r_underrun;
  assign sync_err  = r_sync_err;
  assign audio_out = r_audio;
  assign timecode  = r_timecode;
  assign midi      = r_midi;
  assign smux      = r_smux;

endmodule

// File: tb/tb_adat_tx_frame_sequencer.sv
// Directed bench for adat_tx_frame_sequencer: frame timing, fill/commit, sync errors,
// underrun handling, user-bit latching, enable/reset behaviour.
module tb_adat_tx_frame_sequencer;

  localparam int unsigned CPF = 2048;
  localparam int unsigned NCH = 8;
  localparam int unsigned SW  = 24;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic                   s_valid;
  logic                   s_ready;
  logic [SW-1:0]          s_data;
  logic                   s_last;
  logic                   user_timecode;
  logic                   user_midi;
  logic                   user_smux;
  logic                   start;
  logic [NCH-1:0][SW-1:0] audio_out;
  logic                   timecode;
  logic                   midi;
  logic                   smux;
  logic                   frame_req;
  logic                   underrun;
  logic                   sync_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  adat_tx_frame_sequencer #(
    .CLKS_PER_FRAME(CPF),
    .NUM_CH        (NCH),
    .SAMPLE_W      (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .user_timecode(user_timecode),
    .user_midi    (user_midi),
    .user_smux    (user_smux),
    .start        (start),
    .audio_out    (audio_out),
    .timecode     (timecode),
    .midi         (midi),
    .smux         (smux),
    .frame_req    (frame_req),
    .underrun     (underrun),
    .sync_err     (sync_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, output int unsigned n);
    n = 0;
    do begin
      tick();
      n++;
    end while (start !== 1'b1 && n < 3000);
    chk({tag, "_start_seen"}, 32'(start), 32'd1);
  endtask

  task automatic send_beat(input logic [SW-1:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  logic [SW-1:0] exp_a0;
  logic [SW-1:0] exp_a7;

  initial begin
    int unsigned n;
    logic        seen;

    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    user_timecode = 1'b0; user_midi = 1'b0; user_smux = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_start",    32'(start),        32'd0);
    chk("rst_sready",   32'(s_ready),      32'd0);
    chk("rst_audio0",   32'(audio_out[0]), 32'd0);
    chk("rst_underrun", 32'(underrun),     32'd0);
    chk("rst_framereq", 32'(frame_req),    32'd0);

    // 1: free run with no input
    enable = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t1_commit_sready", 32'(s_ready), 32'd0);
    chk("t1_no_start_yet",  32'(start),   32'd0);
    tick();
    chk("t1_start",     32'(start),        32'd1);
    chk("t1_framereq",  32'(frame_req),    32'd1);
    chk("t1_underrun",  32'(underrun),     32'd1);
    chk("t1_audio0",    32'(audio_out[0]), 32'd0);
    tick();
    chk("t1_start_pulse",    32'(start),    32'd0);
    chk("t1_underrun_pulse", 32'(underrun), 32'd0);
    wait_start("t1", n);
    chk("t1_period",    n,                 32'd2047);
    chk("t1_underrun2", 32'(underrun),     32'd1);

    // 2: full frame then back-pressure
    chk("t2_sready", 32'(s_ready), 32'd1);
    for (int unsigned c = 0; c < NCH; c++) send_beat(SW'(c + 1), c == NCH - 1);
    s_valid = 1'b1; s_data = 24'h000009;
    #1;
    chk("t2_backpressure", 32'(s_ready), 32'd0);
    tick();
    chk("t2_bp_hold", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    wait_start("t2", n);
    chk("t2_period_rest", n, 32'd2039);
    chk("t2_underrun", 32'(underrun), 32'd0);
    for (int unsigned c = 0; c < NCH; c++)
      chk($sformatf("t2_audio%0d", c), 32'(audio_out[c]), c + 1);

    // 3: misplaced s_last then clean frame
    for (int unsigned c = 0; c < 3; c++) send_beat(SW'(32'h10 + c), 1'b0);
    chk("t3_no_err_yet", 32'(sync_err), 32'd0);
    send_beat(24'h000013, 1'b1);
    chk("t3_sync_err", 32'(sync_err), 32'd1);
    tick();
    chk("t3_sync_err_pulse", 32'(sync_err), 32'd0);
    for (int unsigned c = 0; c < NCH; c++) send_beat(SW'(32'h20 + c), c == NCH - 1);
    wait_start("t3", n);
    chk("t3_underrun", 32'(underrun), 32'd0);
    for (int unsigned c = 0; c < NCH; c++)
      chk($sformatf("t3_audio%0d", c), 32'(audio_out[c]), 32'h20 + c);

    // 4: empty frame after a loaded one
`ifdef ADAT_HOLD_ON_UNDERRUN_EN
    exp_a0 = 24'h000020; exp_a7 = 24'h000027;
`else
    exp_a0 = 24'h000000; exp_a7 = 24'h000000;
`endif
    wait_start("t4", n);
    chk("t4_underrun", 32'(underrun),     32'd1);
    chk("t4_audio0",   32'(audio_out[0]), 32'(exp_a0));
    chk("t4_audio7",   32'(audio_out[7]), 32'(exp_a7));

    // 5: user bits latch only at commit
    repeat (100) tick();
    user_midi = 1'b1; user_timecode = 1'b1;
    tick();
    chk("t5_midi_mid", 32'(midi), 32'd0);
    repeat (1946) tick();
    chk("t5_commit_nostart", 32'(start), 32'd0);
    chk("t5_midi_commit",    32'(midi),  32'd0);
    tick();
    chk("t5_start",    32'(start),    32'd1);
    chk("t5_midi",     32'(midi),     32'd1);
    chk("t5_timecode", 32'(timecode), 32'd1);
    chk("t5_smux",     32'(smux),     32'd0);

    // 6: enable low mid-frame, then reset mid-fill
    for (int unsigned c = 0; c < 3; c++) send_beat(SW'(32'h30 + c), 1'b0);
    enable = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (start === 1'b1) seen = 1'b1;
    end
    chk("t6_no_start_disabled", 32'(seen), 32'd0);
    enable = 1'b1;
    #1;
    chk("t6_commit_sready", 32'(s_ready), 32'd0);
    tick();
    chk("t6_start_reenable", 32'(start),    32'd1);
    chk("t6_partial_underrun", 32'(underrun), 32'd1);
    send_beat(24'h000040, 1'b0);
    send_beat(24'h000041, 1'b0);
    reset = 1'b1;
    tick();
    chk("t6_rst_sready", 32'(s_ready),      32'd0);
    chk("t6_rst_start",  32'(start),        32'd0);
    chk("t6_rst_audio0", 32'(audio_out[0]), 32'd0);
    chk("t6_rst_midi",   32'(midi),         32'd0);
    chk("t6_rst_tc",     32'(timecode),     32'd0);
    reset = 1'b0;
    #1;
    chk("t6_rel_nostart", 32'(start), 32'd0);
    tick();
    chk("t6_rel_start",    32'(start),    32'd1);
    chk("t6_rel_underrun", 32'(underrun), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
